// File: rtl/score_display.sv
// rtl/score_display.sv - best-score tracker and multiplexed four-digit seven-segment driver
module score_display #(
    parameter int REFRESH_CYCLES = 100000,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    input  logic       latch_i,
    input  logic       game_over_i,
    input  logic       show_best_i,
    output logic [3:0] anode_no,
    output logic [6:0] segments_no,
    output logic       dp_no
);
    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CYCLES - 1);

    logic [15:0]   cur_q, cur_d;
    logic [15:0]   best_q, best_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    slot_q, slot_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [15:0]   src;
    logic [3:0]    digit;
    logic [3:0]    lead_nz;
    logic          blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    always_comb begin
        cur_d  = latch_i ? {digit3_i, digit2_i, digit1_i, digit0_i} : cur_q;
        // Packed BCD compares correctly as a plain unsigned integer.
        best_d = (game_over_i && (cur_q > best_q)) ? cur_q : best_q;

        cnt_d  = cnt_q + CW'(1);
        slot_d = slot_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            slot_d = slot_q + 2'd1;
        end

        src   = show_best_i ? best_q : cur_q;
        digit = src[{slot_q, 2'b00} +: 4];

        // lead_nz[k]: some digit at position k or above is non-zero.
        lead_nz[3] = |src[15:12];
        lead_nz[2] = lead_nz[3] | (|src[11:8]);
        lead_nz[1] = lead_nz[2] | (|src[7:4]);
        lead_nz[0] = 1'b1;
        blank      = BLANK_LEADING && !lead_nz[slot_q];

        anode_d = blank ? 4'b1111 : ~(4'b0001 << slot_q);
        seg_d   = blank ? 7'b1111111 : seg_decode(digit);
        dp_d    = !(show_best_i && (slot_q == 2'd3) && !blank);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q   <= '0;
            best_q  <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            anode_q <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            cur_q   <= cur_d;
            best_q  <= best_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign anode_no    = anode_q;
    assign segments_no = seg_q;
    assign dp_no       = dp_q;
endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - table-driven and scoreboard bench for score_display
module tb_score_display;
    localparam int RC = 4;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;

    logic       clk_i = 1'b0;
    logic       rst_i, latch_i, game_over_i, show_best_i;
    logic [3:0] digit0_i, digit1_i, digit2_i, digit3_i;
    logic [3:0] anode_no;
    logic [6:0] segments_no;
    logic       dp_no;

    score_display #(.REFRESH_CYCLES(RC), .BLANK_LEADING(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .digit0_i(digit0_i), .digit1_i(digit1_i), .digit2_i(digit2_i), .digit3_i(digit3_i),
        .latch_i(latch_i), .game_over_i(game_over_i), .show_best_i(show_best_i),
        .anode_no(anode_no), .segments_no(segments_no), .dp_no(dp_no)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    typedef struct packed {
        logic        rst_first;
        logic        do_latch;
        logic [15:0] val;
        logic        go_with;
        logic        go_after;
        logic        sb;
        logic [27:0] seg4;
        logic [15:0] an4;
        logic        dp3;
    } vec_t;

    out_t        exp_q[$];
    out_t        last_out;
    logic [15:0] m_cur, m_best;
    int          m_cyc;
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs[11];

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] tbl [10];
        tbl = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
        return (v < 4'd10) ? tbl[v] : SD;
    endfunction

    function automatic out_t ref_out(input logic [15:0] src, input int slot, input logic bm);
        out_t o;
        logic blank;
        blank = (slot != 0) && ((src >> (4 * slot)) == 16'd0);
        if (blank) o = '{an: 4'b1111, seg: SB, dp: 1'b1};
        else begin
            o.an  = 4'b1111;
            o.an[slot] = 1'b0;
            o.seg = ref_seg(4'((src >> (4 * slot)) & 16'hF));
            o.dp  = !(bm && slot == 3);
        end
        return o;
    endfunction

    function automatic vec_t mk(input logic rf, input logic dl, input logic [15:0] val,
                                input logic gw, input logic ga, input logic sb,
                                input logic [27:0] seg4, input logic [15:0] an4, input logic dp3);
        vec_t v;
        v.rst_first = rf; v.do_latch = dl; v.val = val; v.go_with = gw; v.go_after = ga;
        v.sb = sb; v.seg4 = seg4; v.an4 = an4; v.dp3 = dp3;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, got, exp);
        end
    endtask

    // One clock: predict the next output into the scoreboard, advance the model, then compare.
    task automatic tick();
        out_t e, got;
        if (rst_i) e = '{an: 4'b1111, seg: SB, dp: 1'b1};
        else e = ref_out(show_best_i ? m_best : m_cur, (m_cyc / RC) % 4, show_best_i);
        exp_q.push_back(e);
        if (rst_i) begin
            m_cur = 16'd0; m_best = 16'd0; m_cyc = 0;
        end else begin
            if (game_over_i && m_cur > m_best) m_best = m_cur;
            if (latch_i) m_cur = {digit3_i, digit2_i, digit1_i, digit0_i};
            m_cyc++;
        end
        @(posedge clk_i);
        #1;
        got = '{an: anode_no, seg: segments_no, dp: dp_no};
        last_out = got;
        check($sformatf("scoreboard_cyc%0d", m_cyc), got, exp_q.pop_front());
    endtask

    task automatic set_digits(input logic [15:0] v);
        {digit3_i, digit2_i, digit1_i, digit0_i} = v;
    endtask

    initial begin
        int c, slot;
        vec_t v;
        rst_i = 1'b1; latch_i = 1'b0; game_over_i = 1'b0; show_best_i = 1'b0;
        set_digits(16'h0000);
        m_cur = '0; m_best = '0; m_cyc = 0;

        // Reset then idle scan: only slot 0 lit, 16-cycle period.
        tick(); check("reset_out0", last_out, {4'b1111, SB, 1'b1});
        tick(); check("reset_out1", last_out, {4'b1111, SB, 1'b1});
        rst_i = 1'b0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (k % 16 < 4) check($sformatf("idle_scan%0d", k), last_out, {4'b1110, S0, 1'b1});
            else            check($sformatf("idle_scan%0d", k), last_out, {4'b1111, SB, 1'b1});
        end

        vecs[0]  = mk(1, 1, 16'h1003, 0, 0, 0, {S1, S0, S0, S3}, 16'h7BDE, 1);
        vecs[1]  = mk(0, 1, 16'h0123, 0, 1, 0, {SB, S1, S2, S3}, 16'hFBDE, 1);
        vecs[2]  = mk(0, 1, 16'h0099, 0, 1, 1, {SB, S1, S2, S3}, 16'hFBDE, 1);
        vecs[3]  = mk(0, 1, 16'h1500, 0, 1, 1, {S1, S5, S0, S0}, 16'h7BDE, 0);
        vecs[4]  = mk(1, 1, 16'h0123, 0, 1, 0, {SB, S1, S2, S3}, 16'hFBDE, 1);
        vecs[5]  = mk(0, 1, 16'h0200, 1, 0, 0, {SB, S2, S0, S0}, 16'hFBDE, 1);
        vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 1, {SB, S1, S2, S3}, 16'hFBDE, 1);
        vecs[7]  = mk(0, 1, 16'h000C, 0, 0, 0, {SB, SB, SB, SD}, 16'hFFFE, 1);
        vecs[8]  = mk(0, 1, 16'h9876, 0, 0, 0, {S9, S8, S7, S6}, 16'h7BDE, 1);
        vecs[9]  = mk(0, 1, 16'h0040, 0, 0, 0, {SB, SB, S4, S0}, 16'hFFDE, 1);
        vecs[10] = mk(0, 1, 16'h0124, 0, 1, 1, {SB, S1, S2, S4}, 16'hFBDE, 1);

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            if (v.rst_first) begin
                rst_i = 1'b1; tick(); rst_i = 1'b0;
            end
            if (v.do_latch) begin
                set_digits(v.val); latch_i = 1'b1; game_over_i = v.go_with;
                tick();
                latch_i = 1'b0; game_over_i = 1'b0;
            end
            if (v.go_after) begin
                game_over_i = 1'b1; tick(); game_over_i = 1'b0;
            end
            show_best_i = v.sb;
            while (m_cyc % (4 * RC) != 0) tick();
            for (int k = 0; k < 4 * RC; k++) begin
                c = m_cyc;
                tick();
                if (c % RC == 0) begin
                    slot = (c / RC) % 4;
                    check($sformatf("vec%0d_slot%0d", i, slot), last_out,
                          {v.an4[slot*4 +: 4], v.seg4[slot*7 +: 7], (slot == 3) ? v.dp3 : 1'b1});
                end
            end
        end

        // Reset landing in slot 2, counter 1, clears cur and best.
        set_digits(16'h1003); latch_i = 1'b1; tick(); latch_i = 1'b0;
        game_over_i = 1'b1; tick(); game_over_i = 1'b0;
        show_best_i = 1'b1;
        while (m_cyc % (4 * RC) != 2 * RC + 1) tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        check("midreset_out", last_out, {4'b1111, SB, 1'b1});
        tick();
        check("midreset_slot0", last_out, {4'b1110, S0, 1'b1});
        for (int k = 0; k < 4 * RC; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/score_display.md
# score_display

Downstream consumer of the four BCD score digits produced by the game's score counter. Snapshots the live score on command, tracks the best score across games, and drives a four-digit common-anode seven-segment display by time-multiplexing one digit at a time, with leading-zero blanking. Sits between the score counter and the board's display pins.

## Interface

- REFRESH_CYCLES, 100000: clock cycles each digit slot stays lit. Legal values are ≥ 1.
- BLANK_LEADING, 1: 1 enables leading-zero blanking; 0 shows all four digits always.

- clk_i  input  1  single clock; all state updates on the rising edge
- rst_i  input  1  synchronous, active-high reset
- digit0_i..digit3_i  input  4 each  BCD score digits; digit0 is the ones digit
- latch_i  input  1  when high, copy digit inputs into the current-score register
- game_over_i  input  1  when high, update best score if current > best
- show_best_i  input  1  1 displays the best score; 0 displays the current score
- anode_no  output  4  active-low digit enables; bit k drives digit k, rightmost = bit 0
- segments_no  output  7  active-low segments, order {g,f,e,d,c,b,a}
- dp_no  output  1  active-low decimal point

## Operation

- **cur register (16 bits BCD)**
  - Loads {digit3_i..digit0_i} on any cycle with latch_i = 1.
  - Reset value 0000.
- **best register (16 bits BCD)**
  - On game_over_i = 1, loads cur if cur > best; otherwise holds.
  - Comparison is unsigned, digit3 most significant.
  - Compares the pre-edge value of cur.
  - If latch_i and game_over_i are high together, best compares the old cur and cur still loads the new inputs.
  - Reset value 0000.
- **Scan counter**
  - Counts 0..REFRESH_CYCLES-1 and wraps to 0.
  - On wrap, slot advances 0→1→2→3→0.
  - Counter width is $clog2(REFRESH_CYCLES), minimum 1.
  - Reset: counter 0, slot 0.
- **Source selection**
  - src = show_best_i ? best : cur, evaluated every cycle. No hold to a slot boundary.
- **Blanking**
  - With BLANK_LEADING = 1, digit k (k ≥ 1) is blanked if src digits k..3 are all zero.
  - Digit 0 is never blanked.
  - A blanked slot drives anode_no = 4'b1111 and segments_no = 7'b1111111.
- **Segment decoding**
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - Non-BCD values 10–15 display a dash: 0111111.
- **Anode drive**
  - Unblanked slot k drives anode_no with only bit k low, e.g. slot 2 → 4'b1011.
- **Decimal point**
  - dp_no = 0 only when show_best_i = 1, slot = 3 and slot 3 is unblanked; otherwise 1.
  - Marks best-score mode.
- **Output registers**
  - anode_no, segments_no and dp_no are registered; no combinational path from inputs to outputs.
  - Reset values: anode_no 4'b1111, segments_no 7'b1111111, dp_no 1.

## Timing

- rst_i is sampled at the clock edge.
  - Asserting it at any point, including mid-slot, forces every register to its reset value at that edge.
  - The first cycle after release begins slot 0 with counter 0.
- Output latency is 1 cycle.
  - Outputs at edge N+1 reflect slot, src and show_best_i as of cycle N.
  - A latch_i pulse at edge N appears on the display at edge N+1 if the current slot shows a changed digit.
- Slot duration is exactly REFRESH_CYCLES cycles; a full scan takes 4·REFRESH_CYCLES cycles.
- With REFRESH_CYCLES = 1, the slot advances every cycle.
- game_over_i held high for multiple cycles is harmless: repeated compares are idempotent.
- latch_i held high tracks the inputs every cycle.

## Test plan

All scenarios use REFRESH_CYCLES = 4 and BLANK_LEADING = 1.

- **Reset and idle scan**
  - Stimulus: rst_i high 2 cycles, then low.
  - Required: during reset, outputs are 1111 / 1111111 / 1.
  - One edge after release: anode 1110, segments 1000000 for 4 cycles.
  - Slots 1–3 blanked (anode 1111); the pattern repeats every 16 cycles.
- **Blanking with interior zeros**
  - Stimulus: latch digits 3,0,0,1 (digit3..digit0 = 1,0,0,3, value 1003).
  - Required: slot0 shows 0110000 on anode 1110.
  - Slots 1 and 2 show 1000000 on anodes 1101 and 1011.
  - Slot 3 shows 1111001 on anode 0111.
- **Best tracking**
  - Stimulus: latch 0123, pulse game_over; latch 0099, pulse game_over; raise show_best_i.
  - Required: slot1 shows 2 (0100100).
  - Slot3 is blanked with dp_no 1, because digit3 is 0.
  - Then latch and game_over 1500: slot3 shows 1 with dp_no 0.
- **Simultaneous latch and game_over**
  - Stimulus: cur = 0123, best = 0123; in the same cycle, latch 0200 and game_over.
  - Required: best stays 0123; cur becomes 0200.
  - With show_best_i = 0, slot2 shows 2.
- **Invalid BCD**
  - Stimulus: latch digit0 = 12.
  - Required: slot0 segments 0111111.
- **Reset mid-scan**
  - Stimulus: assert rst_i for 1 cycle during slot 2, counter 1.
  - Required: the next edge gives reset outputs with cur and best 0000.
  - The following edge gives slot 0, anode 1110, segments 1000000.
